// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (see fetch_pc_reg / instr_fetch_unit).
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  // HALT is only reachable when the misaligned-redirect trap is built in.
  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4,
    HALT = 3'd5
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: sequential increment, redirect load with word
// alignment, and misaligned-redirect detection.
// FETCH_MISALIGN_TRAP_EN defined: a misaligned redirect raises a sticky fault
// and freezes the pc. Undefined: the low two address bits are simply dropped.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc,
  output logic            trap,
  output logic            fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  // A redirect traps only while no fault is latched; afterwards redirects are ignored.
  assign trap  = load && (load_pc[1:0] != 2'b00) && !fault_q;
  assign fault = fault_q;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)    fault_q <= 1'b0;
    else if (trap) fault_q <= 1'b1;
  end

  // Redirect beats increment; a trapping or post-fault redirect leaves pc untouched.
  always_ff @(posedge clk) begin
    if (!rst_n)                          pc <= RESET_PC;
    else if (load && !trap && !fault_q)  pc <= align_word(load_pc);
    else if (inc && !fault_q)            pc <= pc + XLEN'(4);
  end
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;

  // Redirect beats increment; increment wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= align_word(load_pc);
    else if (inc)  pc <= pc + XLEN'(4);
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read to instruction memory,
// instruction handed to the decoder over valid/ready, redirects squash stale
// fetches. Optional macro FETCH_MISALIGN_TRAP_EN enables the misaligned
// redirect trap (fetch_fault, fetch halts).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid is driven from state only and never depends on ready in the same
// cycle, and once raised it stays high with stable payload until the transfer
// (a redirect is the only thing that withdraws a request or held instruction).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            pc_inc;
  logic            trap;
  logic            fault;
  logic            req_accept;
  logic            rsp_take;

  assign req_accept = (state == REQ) && imem_req_ready;
  // A redirect in the same cycle as acceptance sends the fetch to DROP instead.
  assign pc_inc     = req_accept && !redirect_valid;
  assign rsp_take   = (state == WAIT) && imem_rsp_valid && !redirect_valid;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (pc_inc),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .pc      (pc),
    .trap    (trap),
    .fault   (fault)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_d;
  end

  // Next-state logic; redirect outranks every other event.
  always_comb begin
    state_d = state;
    case (state)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_valid)      state_d = imem_req_ready ? DROP : REQ;
        else if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid)      state_d = imem_rsp_valid ? REQ : DROP;
        else if (imem_rsp_valid) state_d = HOLD;
      end
      HOLD: begin
        if (redirect_valid || instr_ready) state_d = REQ;
      end
      // A redirect here only moves pc; the stale response must still drain.
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (trap) state_d = HALT;
  end

  // Capture the accepted address and the returned instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      if (pc_inc) fetch_pc <= pc;
      if (rsp_take) begin
        instr_q    <= imem_rsp_data;
        instr_pc_q <= fetch_pc;
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = instr_q[6:0];
  assign fetch_fault    = fault;
  assign dbg_state      = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand sequences for fetch timing and
// redirect corner cases, then a table of redirect targets.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data = 32'h0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic [6:0]   opcode;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         fetch_fault;
  fetch_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  // memory model state
  int          lat = 1;
  bit          pend = 1'b0;
  int          left = 0;
  logic [31:0] paddr = 32'h0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[$];

  // clock
  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h1555_5555, 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record handshake before the edge, then update the memory model
  // at the following falling edge.
  task automatic cycle();
    bit          acc;
    logic [31:0] aaddr;
    acc   = imem_req_valid && imem_req_ready;
    aaddr = imem_req_addr;
    @(negedge clk);
    if (imem_rsp_valid) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      left  = lat;
      paddr = aaddr;
    end
    if (pend) left = left - 1;
    imem_rsp_valid = pend && (left == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(paddr) : 32'h0BAD_0BAD;
  endtask

  // Starting in REQ: fetch one word at address a, optionally stall in HOLD.
  task automatic fetch_one(input logic [31:0] a, input int stall);
    logic [31:0] w;
    w = mem_word(a);
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_req_addr, a);
    imem_req_ready = 1'b1;
    cycle();
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("wait_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    chk("hold_instr_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr_pc", instr_pc, a);
    chk("hold_instr", instr, w);
    chk("hold_opcode", 32'(opcode), 32'(w[6:0]));
    for (int i = 0; i < stall; i++) begin
      cycle();
      chk("stall_instr_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr_pc", instr_pc, a);
      chk("stall_instr", instr, w);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{32'h0000_0040, 32'h0000_0040, 32'h0000_0044});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0004});
    vecs.push_back('{32'h1234_5678, 32'h1234_5678, 32'h1234_567C});
    vecs.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
`ifndef FETCH_MISALIGN_TRAP_EN
    vecs.push_back('{32'h0000_0102, 32'h0000_0100, 32'h0000_0104});
    vecs.push_back('{32'h0000_0007, 32'h0000_0004, 32'h0000_0008});
`endif

    // reset
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(BOOT));

    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
    cycle();
    chk("first_req_state", 32'(dbg_state), 32'(REQ));

    // sequential fetches, second one stalled in HOLD
    fetch_one(32'h0, 0);
    fetch_one(32'h4, 5);

    // redirect in the same cycle as acceptance at 0x8
    chk("pre_accept_redir_addr", imem_req_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    chk("acc_redir_state", 32'(dbg_state), 32'(DROP));
    chk("acc_redir_req_valid", 32'(imem_req_valid), 32'd0);
    chk("acc_redir_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    chk("acc_redir_no_stale", 32'(instr_valid), 32'd0);
    fetch_one(32'h200, 0);

    // redirect in WAIT, stale response arrives the cycle after
    lat = 2;
    cycle();
    chk("wait_state", 32'(dbg_state), 32'(WAIT));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    lat = 1;
    chk("wait_redir_state", 32'(dbg_state), 32'(DROP));
    chk("wait_redir_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    chk("wait_redir_back_req", 32'(dbg_state), 32'(REQ));
    chk("wait_redir_no_stale", 32'(instr_valid), 32'd0);
    fetch_one(32'h100, 0);

    // redirect in HOLD with the decoder consuming in the same cycle
    cycle();
    cycle();
    chk("hold_pc_104", instr_pc, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    instr_ready    = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("hold_redir_instr_valid", 32'(instr_valid), 32'd0);
    chk("hold_redir_state", 32'(dbg_state), 32'(REQ));
    fetch_one(32'h300, 0);

    // table: redirect while in REQ (not accepted), then fetch the target
    foreach (vecs[i]) begin
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      cycle();
      redirect_valid = 1'b0;
      fetch_one(vecs[i].exp_addr, 0);
      chk("vec_next_addr", imem_req_addr, vecs[i].exp_next);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    chk("trap_fault", 32'(fetch_fault), 32'd1);
    chk("trap_req_valid", 32'(imem_req_valid), 32'd0);
    chk("trap_instr_valid", 32'(instr_valid), 32'd0);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) cycle();
    chk("trap_still_idle", 32'(imem_req_valid), 32'd0);
    chk("trap_sticky", 32'(fetch_fault), 32'd1);
`else
    chk("no_fault", 32'(fetch_fault), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the main decoder in the RV32I core. Keeps the program counter, issues one word-aligned read at a time to instruction memory over a valid/ready request and valid response channel, and presents the returned instruction, its PC and its opcode field to the decoder with a valid/ready handshake. Branch/jump resolution redirects the PC and squashes stale fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)
- XLEN, 32, address/data width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  read data valid, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instruction available to decoder
- instr_ready  in  1  decoder consumes instruction
- instr  out  32  instruction word
- instr_pc  out  XLEN  address of instr
- opcode  out  7  instr[6:0], feeds decoder opcode input
- redirect_valid  in  1  taken branch or jump resolved
- redirect_pc  in  XLEN  new fetch address
- fetch_fault  out  1  misaligned redirect trap (see Configuration)

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, DROP. Reset loads BOOT.
- BOOT: all handshake outputs 0; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On accept: fetch_pc <= pc, pc <= pc+4 (mod 2^32, FFFF_FFFC wraps to 0), -> WAIT.
- WAIT: on imem_rsp_valid: instr <= imem_rsp_data, instr_pc <= fetch_pc, -> HOLD.
- HOLD: instr_valid=1; outputs stable until instr_ready; on instr_ready -> REQ.
- DROP: one stale response outstanding; on imem_rsp_valid discard data, -> REQ.
- Redirect has priority over all other events; pc <= redirect_pc:
  - BOOT: pc updated, -> REQ.
  - REQ, not accepted same cycle: stay REQ, new address next cycle. Accepted same cycle: -> DROP.
  - WAIT: -> DROP; if imem_rsp_valid same cycle, discard and -> REQ.
  - HOLD: held instruction discarded (instr_valid drops next cycle even if instr_ready same cycle; decoder handoff that cycle still counts as consumed), -> REQ.
  - DROP: pc updated, stay DROP.
- At most one outstanding request; imem_rsp_valid outside WAIT/DROP ignored.
- opcode = instr[6:0] always.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, opcode 0, fetch_fault 0, pc RESET_PC.
- First request cycle is the second rising edge after rst_n high (BOOT then REQ).
- Zero-wait memory (ready=1, response next cycle): one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect-to-request latency: 1 cycle (REQ asserted with redirect_pc on the following cycle unless in DROP).
- rst_n low in any state: next edge -> BOOT, pending response is dropped by the memory-side contract (memory is reset with the core).
- All outputs are registers or decode of the state register; no combinational path from inputs to outputs.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 sets fetch_fault (sticky until reset), FSM enters HOLD-free idle (no requests, instr_valid 0); later redirects ignored.
- Undefined: redirect_pc[1:0] forced to 0; fetch_fault tied 0.

## Structure
- Package fetch_pkg: FSM state enum, NOP constant 32'h0000_0013, default RESET_PC.
- Sub-module fetch_pc_reg: pc register with increment, redirect load, alignment masking/fault detect.

## Test plan
- Reset release, ready=1, 1-cycle response memory returning words at 0,4,8 -> instr_pc 0,4,8 each 3 cycles, opcode matches instr[6:0].
- instr_ready held 0 for 5 cycles in HOLD -> instr and instr_pc stable, no new request.
- Redirect to 0x100 in WAIT, response arrives next cycle -> response dropped, next request addr 0x100, instr_pc 0x100 delivered.
- Redirect same cycle as request acceptance at 0x8 -> DROP, stale word never presented, next request 0x200 as redirected.
- pc at FFFF_FFFC fetched -> next request address 0x0000_0000.
- Redirect to 0x102: with FETCH_MISALIGN_TRAP_EN fetch_fault=1 and no further requests; without it next request address 0x100.
